// File: rtl/aes_key_schedule_ctrl.sv
// aes_key_schedule_ctrl: expands a 128-bit AES key into round keys 0..NR through one combinational keyExp stage per cycle.
module keyExp (
  input  logic [3:0]   rcRound,
  input  logic [127:0] keyIn,
  output logic [127:0] keyOut
);
  localparam logic [7:0] RCON [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                       8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box as GF(2^8) inverse (x^254 by repeated squaring) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s, r;
    s = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  logic [31:0] temp, n0, n1, n2, n3;
  always_comb begin
    temp = {sbox(keyIn[23:16]), sbox(keyIn[15:8]), sbox(keyIn[7:0]), sbox(keyIn[31:24])}
           ^ {RCON[rcRound], 24'h0};
    n0 = keyIn[127:96] ^ temp;
    n1 = keyIn[95:64] ^ n0;
    n2 = keyIn[63:32] ^ n1;
    n3 = keyIn[31:0] ^ n2;
    keyOut = {n0, n1, n2, n3};
  end
endmodule

module aes_key_schedule_ctrl #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  input  logic [3:0]       rk_rd_addr,
  output logic [KEY_W-1:0] rk_rd_data
);
  typedef enum logic {IDLE, EXPAND} state_t;
  state_t state, nextState;
  logic [3:0] round;
  logic [KEY_W-1:0] curKey, keyOut;
  logic [KEY_W-1:0] rk [NR+1];
  logic accept, lastRound;
  keyExp uKeyExp (.rcRound(round), .keyIn(curKey), .keyOut(keyOut));
  always_comb begin
    key_ready = state == IDLE;
    busy = state == EXPAND;
    accept = key_valid && key_ready;
    lastRound = round == 4'(NR - 1);
    nextState = accept ? EXPAND : (busy && lastRound) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      round <= '0;
      done <= 1'b0;
      keys_valid <= 1'b0;
      rk_rd_data <= '0;
    end else begin
      state <= nextState;
      done <= busy && lastRound;
      rk_rd_data <= (rk_rd_addr <= 4'(NR)) ? rk[rk_rd_addr] : '0;
      if (accept) begin
        curKey <= key_in;
        round <= '0;
        keys_valid <= 1'b0;
      end
      if (busy) begin
        curKey <= keyOut;
        round <= lastRound ? '0 : round + 4'd1;
        keys_valid <= lastRound;
      end
    end
  end
  // Storage is deliberately not reset; keys_valid alone qualifies its contents
  always_ff @(posedge clk) begin
    if (!rst && accept) rk[0] <= key_in;
    if (!rst && busy) rk[round + 4'd1] <= keyOut;
  end
endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// tb_aes_key_schedule_ctrl: checks the key schedule controller against a word-level FIPS-197 expansion model.
module tb_aes_key_schedule_ctrl;
  logic clk = 1'b0, rst = 1'b1, key_valid = 1'b0, key_ready, busy, done, keys_valid;
  logic [127:0] key_in = '0, rk_rd_data;
  logic [3:0] rk_rd_addr = '0;
  int checks = 0, errors = 0;
  logic [7:0] sb [256];
  logic [127:0] mk [11];
  typedef struct {logic [127:0] key, rk1, rk10;} vec_t;
  vec_t tv [4];
  localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_schedule_ctrl dut (.clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in), .busy(busy), .done(done), .keys_valid(keys_valid),
    .rk_rd_addr(rk_rd_addr), .rk_rd_data(rk_rd_data));

  always #5 clk = ~clk;

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic buildSbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = 8'h63;
      for (int i = 0; i < 8; i++)
        s[i] = s[i] ^ inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
      sb[x] = s;
    end
  endtask

  task automatic model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) mk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doAccept(input logic [127:0] key);
    int n = 0;
    key_in = key;
    key_valid = 1'b1;
    while (!key_ready && n < 100) begin tick(); n++; end
    chk("accept_timeout", 128'(n < 100), 128'd1);
    tick();
    key_valid = 1'b0;
    chk("busy_after_accept", {key_ready, busy}, 128'b01);
  endtask

  task automatic waitDone(input int expN, input string nm);
    int n = 0, low = key_ready ? 0 : 1;
    while (n < 40) begin
      tick();
      n++;
      if (done) break;
      if (!key_ready) low++;
    end
    chk({nm, "_latency"}, 128'(n), 128'(expN));
    chk({nm, "_ready_low"}, 128'(low), 128'(expN));
    chk({nm, "_kv"}, {keys_valid, key_ready, busy}, 128'b110);
  endtask

  task automatic rd(input int a, input logic [127:0] exp, input string nm);
    rk_rd_addr = 4'(a);
    tick();
    chk(nm, rk_rd_data, exp);
  endtask

  initial begin
    logic [127:0] ka, k2;
    int sawDone, sawReady;
    buildSbox();
    tv[0] = '{FIPS, 128'ha0fafe1788542cb123a339392a6c7605, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tv[1] = '{128'h0, 128'h62636363626363636263636362636363, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    for (int i = 2; i < 4; i++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      model(ka);
      tv[i] = '{ka, mk[1], mk[10]};
    end
    tick(); tick();
    chk("reset_state", {key_ready, busy, done, keys_valid}, 128'b1000);
    chk("reset_rd", rk_rd_data, 128'h0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      doAccept(tv[i].key);
      waitDone(10, $sformatf("vec%0d", i));
      rd(0, tv[i].key, $sformatf("vec%0d_rk0", i));
      chk($sformatf("vec%0d_done_pulse", i), 128'(done), 128'd0);
      rd(1, tv[i].rk1, $sformatf("vec%0d_rk1", i));
      rd(10, tv[i].rk10, $sformatf("vec%0d_rk10", i));
    end

    ka = {$urandom, $urandom, $urandom, $urandom};
    doAccept(ka);
    key_valid = 1'b1;
    sawReady = 0;
    for (int i = 0; i < 8; i++) begin
      key_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (key_ready) sawReady = 1;
    end
    key_valid = 1'b0;
    chk("ignore_ready_low", 128'(sawReady), 128'd0);
    waitDone(2, "ignore");
    model(ka);
    rd(1, mk[1], "ignore_rk1");
    rd(10, mk[10], "ignore_rk10");

    doAccept(FIPS);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_state", {key_ready, busy, done, keys_valid}, 128'b1000);
    chk("midrst_rd", rk_rd_data, 128'h0);
    sawDone = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done || keys_valid) sawDone = 1;
    end
    chk("midrst_no_done", 128'(sawDone), 128'd0);
    doAccept(FIPS);
    waitDone(10, "midrst_redo");
    rd(10, tv[0].rk10, "midrst_rk10");

    ka = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    key_in = ka;
    key_valid = 1'b1;
    tick();
    waitDone(10, "b2b_first");
    key_in = k2;
    tick();
    chk("b2b_second_accept", {done, keys_valid, busy, key_ready}, 128'b0010);
    key_valid = 1'b0;
    waitDone(10, "b2b_second");
    model(k2);
    for (int a = 0; a < 16; a++) rd(a, a <= 10 ? mk[a] : 128'h0, $sformatf("sweep%0d", a));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_key_schedule_ctrl.md
Name: aes_key_schedule_ctrl

Overview:
Sequential key-schedule controller that sits directly upstream of the combinational keyExp round-key stage. It drives keyExp's rcRound and keyIn, and registers keyExp's keyOut once per clock. It accepts a 128-bit cipher key over a valid/ready handshake and builds all NR+1 round keys into an internal register file. The round keys are served to the cipher datapath through a registered read port.

Parameters:
NR, 10, number of AES rounds; round keys 0..NR are stored; fixed at 10 for AES-128, other values are unsupported.
KEY_W, 128, key and round-key width in bits.

Ports:
clk  in  1  single system clock; all state updates on the rising edge.
rst  in  1  reset; synchronous and active-high.
key_valid  in  1  cipher key offered on key_in.
key_ready  out  1  block can accept a key (high only in IDLE).
key_in  in  KEY_W  cipher key; bits [127:96] are word w0.
busy  out  1  expansion in progress.
done  out  1  one-cycle pulse when round key NR has been written.
keys_valid  out  1  level; the full schedule for the last accepted key is stored.
rk_rd_addr  in  4  round-key index to read, 0..NR.
rk_rd_data  out  KEY_W  registered round-key read data.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE, key_ready=1, busy=0, done=0, keys_valid=0, rk_rd_data=0, round counter=0. Round-key storage is not cleared.
- Instantiates keyExp exactly once.
  - rcRound = round counter (4 bits).
  - keyIn = cur_key register.
  - keyExp is combinational, with no added pipeline stage.
- FSM has two states: IDLE and EXPAND.
- IDLE:
  - key_ready=1, busy=0.
  - On the edge where key_valid&&key_ready (edge E0):
    - rk[0]<=key_in, cur_key<=key_in, round<=0.
    - keys_valid<=0, state<=EXPAND.
- EXPAND:
  - key_ready=0, busy=1.
  - At each edge: rk[round+1]<=keyOut, cur_key<=keyOut, round<=round+1.
  - At the edge where round==NR-1 (edge E_NR): write rk[NR], state<=IDLE, done<=1, keys_valid<=1, round<=0.
- Latency:
  - Accept at E0; rk[k] is written at edge Ek.
  - done and keys_valid are visible after E10, i.e. 10 cycles after accept.
  - key_ready is low for exactly 10 cycles.
- done is high for exactly one cycle, then returns to 0.
- key_valid while busy is ignored and no state changes. The source must hold key_in until the handshake.
- Back-to-back keys: if key_valid is high at E10+1, the new key is accepted on that edge. In that case keys_valid falls on the same edge as done falls.
- Read port:
  - rk_rd_data<=rk[rk_rd_addr] on every clock, giving 1-cycle read latency.
  - rk_rd_addr>NR returns all zeros.
  - Reads are permitted at any time. Entries not yet rewritten during EXPAND return stale data; consumers qualify reads with keys_valid.
  - A read of rk[k] on the edge Ek that writes it returns the old value (read-before-write).
- rst mid-EXPAND:
  - FSM returns to IDLE and all outputs take their reset values.
  - keys_valid=0 until a complete new expansion finishes.
  - Partially written storage is never reported valid.
- The round counter never exceeds NR-1 in EXPAND and never wraps.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c accepted with one-cycle key_valid -> key_ready low for 10 cycles; done pulses once, 10 cycles after accept; rk[1]=a0fafe1788542cb123a339392a6c7605; rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key -> rk[0]=0, rk[1]=62636363626363636263636362636363, rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e; keys_valid=1 after done.
- Second key offered during EXPAND (key_valid held, key_in changes mid-run) -> ignored; no second accept until key_ready rises; schedule matches only the first key.
- Assert rst at cycle 5 of an expansion -> next cycle busy=0, key_ready=1, keys_valid=0, done never pulses; a fresh FIPS key then expands correctly.
- Read sweep rk_rd_addr 0..15 after done -> data one cycle after each address; 0..10 match the expected schedule; 11..15 read 0.
- key_valid held high continuously with two different keys -> second accept on the cycle after done; keys_valid drops on the same edge; second schedule is correct.
